mmio_port_responder: RTL and testbench

- Memory-mapped I/O responder on the MEM-stage data bus of the pipelined MIPS core.
- The core initiates the load and store accesses. This block decodes its own address window and answers them.
- It owns the 32-bit PortOut register and a synchronized 8-bit PortIn.
- It keeps a small FIFO that captures every change on PortIn, so software can poll input events without missing any.

---
 rtl/mmio_port_responder.sv | 158 +++++++++++++++
 tb/tb_mmio_port_responder.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_port_responder.sv
// Memory-mapped I/O responder for the MEM-stage data bus.
// It owns the PortOut register, a two-flop synchronized PortIn, and a small
// FIFO that records every change seen on the synchronized input.
//
// Register window (word offset = Address[3:2]):
//   0x0 OUT    r/w   output port
//   0x4 IN     r     synchronized PortIn, zero-extended
//   0x8 STATUS r/w1c bit0 not empty, bit1 full, bit2 overflow (sticky, W1C),
//                    bits[7:4] count
//   0xC POP    r     oldest event, popped at the edge that ends the load
module mmio_port_responder #(
    parameter logic [31:0] IO_BASE    = 32'hFFFF_0000,
    parameter int          FIFO_DEPTH = 4,
    parameter int          IN_WIDTH   = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         Address,
    input  logic [31:0]         WriteData,
    input  logic                MemWrite,
    input  logic                MemRead,
    input  logic [IN_WIDTH-1:0] PortIn,
    output logic [31:0]         ReadData,
    output logic                IOHit,
    output logic [31:0]         PortOut,
    output logic                EventPending
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] OFF_OUT    = 2'd0;
    localparam logic [1:0] OFF_IN     = 2'd1;
    localparam logic [1:0] OFF_STATUS = 2'd2;
    localparam logic [1:0] OFF_POP    = 2'd3;

    logic [1:0]          regOffset;
    logic                rdAccess;
    logic                wrAccess;

    logic [IN_WIDTH-1:0] syncStage1;
    logic [IN_WIDTH-1:0] syncStage2;
    logic [IN_WIDTH-1:0] prevIn;

    logic [IN_WIDTH-1:0] fifoMem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wrPtr;
    logic [PTR_W-1:0]    rdPtr;
    logic [CNT_W-1:0]    count;
    logic                overflow;

    logic                fifoFull;
    logic                fifoEmpty;
    logic                pushReq;
    logic                pushDo;
    logic                popDo;
    logic                ovfSet;
    logic                ovfClr;
    logic [31:0]         statusWord;

    assign IOHit     = (Address[31:4] == IO_BASE[31:4]);
    assign regOffset = Address[3:2];
    assign rdAccess  = MemRead & IOHit;
    assign wrAccess  = MemWrite & IOHit;

    assign fifoFull  = (count == CNT_W'(FIFO_DEPTH));
    assign fifoEmpty = (count == '0);

    // A pop on an empty FIFO is a no-op; a push while full only lands if a
    // pop frees a slot in the same edge, otherwise it is dropped and flagged.
    assign pushReq = (syncStage2 != prevIn);
    assign popDo   = rdAccess & (regOffset == OFF_POP) & ~fifoEmpty;
    assign pushDo  = pushReq & (~fifoFull | popDo);
    assign ovfSet  = pushReq & fifoFull & ~popDo;
    assign ovfClr  = wrAccess & (regOffset == OFF_STATUS) & WriteData[2];

    assign EventPending = ~fifoEmpty;

    // Output port register, written by stores to offset 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            PortOut <= '0;
        end else if (wrAccess && (regOffset == OFF_OUT)) begin
            PortOut <= WriteData;
        end
    end

    // Two-flop synchronizer plus the previous-value register for change detect.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            syncStage1 <= '0;
            syncStage2 <= '0;
            prevIn     <= '0;
        end else begin
            syncStage1 <= PortIn;
            syncStage2 <= syncStage1;
            prevIn     <= syncStage2;
        end
    end

    // FIFO storage; contents are only observable while count is non-zero,
    // so the array itself needs no reset.
    always_ff @(posedge clk) begin
        if (pushDo) begin
            fifoMem[wrPtr] <= syncStage2;
        end
    end

    // FIFO pointers, occupancy and sticky overflow (set beats clear).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (pushDo) begin
                wrPtr <= wrPtr + PTR_W'(1);
            end
            if (popDo) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            case ({pushDo, popDo})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (ovfSet) begin
                overflow <= 1'b1;
            end else if (ovfClr) begin
                overflow <= 1'b0;
            end
        end
    end

    // STATUS word assembled from registered FIFO state.
    always_comb begin
        statusWord              = '0;
        statusWord[0]           = ~fifoEmpty;
        statusWord[1]           = fifoFull;
        statusWord[2]           = overflow;
        statusWord[4 +: CNT_W]  = count;
    end

    // Combinational load data; zero unless this block is the load target.
    always_comb begin
        ReadData = '0;
        if (rdAccess) begin
            case (regOffset)
                OFF_OUT:    ReadData = PortOut;
                OFF_IN:     ReadData = 32'(syncStage2);
                OFF_STATUS: ReadData = statusWord;
                OFF_POP:    ReadData = fifoEmpty ? 32'd0 : 32'(fifoMem[rdPtr]);
                default:    ReadData = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_port_responder.sv
// Directed self-checking bench for mmio_port_responder.
// Inputs are driven 1 ns after the rising edge; combinational reads are
// sampled 2 ns after the edge, registered state 1 ns after the edge.
module tb_mmio_port_responder;

    localparam logic [31:0] BASE     = 32'hFFFF_0000;
    localparam logic [31:0] A_OUT    = BASE + 32'h0;
    localparam logic [31:0] A_IN     = BASE + 32'h4;
    localparam logic [31:0] A_STATUS = BASE + 32'h8;
    localparam logic [31:0] A_POP    = BASE + 32'hC;

    logic        clk;
    logic        reset;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [7:0]  PortIn;
    logic [31:0] ReadData;
    logic        IOHit;
    logic [31:0] PortOut;
    logic        EventPending;

    int nCompared;
    int nMismatched;

    mmio_port_responder #(
        .IO_BASE    (BASE),
        .FIFO_DEPTH (4),
        .IN_WIDTH   (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .Address      (Address),
        .WriteData    (WriteData),
        .MemWrite     (MemWrite),
        .MemRead      (MemRead),
        .PortIn       (PortIn),
        .ReadData     (ReadData),
        .IOHit        (IOHit),
        .PortOut      (PortOut),
        .EventPending (EventPending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCompared++;
        if (obs !== exp) begin
            nMismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Load: sample combinational data mid-cycle, side effects commit at the edge.
    task automatic doRead(input logic [31:0] addr, output logic [31:0] data);
        Address = addr;
        MemRead = 1'b1;
        #1;
        data = ReadData;
        @(posedge clk);
        #1;
        MemRead = 1'b0;
        Address = 32'h0;
    endtask

    task automatic doWrite(input logic [31:0] addr, input logic [31:0] data);
        Address   = addr;
        WriteData = data;
        MemWrite  = 1'b1;
        @(posedge clk);
        #1;
        MemWrite  = 1'b0;
        Address   = 32'h0;
        WriteData = 32'h0;
    endtask

    task automatic setPin(input logic [7:0] v, input int cycles);
        PortIn = v;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic readCheck(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        doRead(addr, d);
        checkVal(tag, d, exp);
    endtask

    initial begin
        logic [31:0] d;
        nCompared   = 0;
        nMismatched = 0;
        reset     = 1'b0;
        Address   = 32'h0;
        WriteData = 32'h0;
        MemWrite  = 1'b0;
        MemRead   = 1'b0;
        PortIn    = 8'hA5;

        // Reset held with activity on the pin
        repeat (3) @(posedge clk);
        #1;
        checkVal("rst_portout", PortOut, 32'h0);
        checkVal("rst_pending", {31'b0, EventPending}, 32'h0);
        readCheck("rst_status", A_STATUS, 32'h0);
        readCheck("rst_in", A_IN, 32'h0);

        // Release: A5 reaches sync2 after 2 edges, pushed on the 3rd
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        readCheck("post_rst_status", A_STATUS, 32'h11);
        readCheck("post_rst_in", A_IN, 32'hA5);
        readCheck("post_rst_pop", A_POP, 32'hA5);
        checkVal("post_rst_pending", {31'b0, EventPending}, 32'h0);

        // Output port
        Address = A_OUT; WriteData = 32'hDEAD_BEEF; MemWrite = 1'b1;
        #1;
        checkVal("out_hit", {31'b0, IOHit}, 32'h1);
        checkVal("out_before_edge", PortOut, 32'h0);
        @(posedge clk);
        #1;
        MemWrite = 1'b0;
        checkVal("out_after_edge", PortOut, 32'hDEAD_BEEF);
        readCheck("out_read", A_OUT, 32'hDEAD_BEEF);
        readCheck("out_read_lowbits", A_OUT + 32'h3, 32'hDEAD_BEEF);
        Address = BASE + 32'h10; WriteData = 32'h1234_5678; MemWrite = 1'b1;
        #1;
        checkVal("miss_hit", {31'b0, IOHit}, 32'h0);
        @(posedge clk);
        #1;
        MemWrite = 1'b0;
        checkVal("miss_portout", PortOut, 32'hDEAD_BEEF);
        readCheck("miss_read", BASE + 32'h10, 32'h0);

        // Store and load together: load sees pre-edge data
        Address = A_OUT; WriteData = 32'h0000_0055; MemWrite = 1'b1; MemRead = 1'b1;
        #1;
        checkVal("rw_read_old", ReadData, 32'hDEAD_BEEF);
        @(posedge clk);
        #1;
        MemWrite = 1'b0; MemRead = 1'b0;
        checkVal("rw_write_new", PortOut, 32'h55);

        // Event capture and pop (A5 -> 00 is itself an event, drain it first)
        setPin(8'h00, 4);
        readCheck("ev_status0", A_STATUS, 32'h11);
        readCheck("ev_pop0", A_POP, 32'h00);
        readCheck("ev_status_empty", A_STATUS, 32'h00);
        setPin(8'h01, 4);
        setPin(8'h03, 4);
        readCheck("ev_status2", A_STATUS, 32'h21);
        readCheck("ev_pop1", A_POP, 32'h01);
        checkVal("ev_pending_mid", {31'b0, EventPending}, 32'h1);
        readCheck("ev_pop2", A_POP, 32'h03);
        checkVal("ev_pending_done", {31'b0, EventPending}, 32'h0);
        readCheck("ev_pop_empty", A_POP, 32'h0);
        readCheck("ev_status_after", A_STATUS, 32'h00);

        // Overflow: 6 changes, last 2 dropped. STATUS = nonempty|full|ovf|count 4
        for (int i = 0; i < 6; i++) setPin(8'h10 + 8'(i), 4);
        readCheck("ovf_status", A_STATUS, 32'h47);
        for (int i = 0; i < 4; i++) readCheck($sformatf("ovf_pop%0d", i), A_POP, 32'h10 + i);
        readCheck("ovf_sticky", A_STATUS, 32'h04);
        doWrite(A_STATUS, 32'hFFFF_FFFB);
        readCheck("ovf_other_bits", A_STATUS, 32'h04);
        doWrite(A_STATUS, 32'h4);
        readCheck("ovf_cleared", A_STATUS, 32'h00);

        // Wrap: pointers move to 3, then the next batch crosses the wrap
        for (int i = 0; i < 3; i++) setPin(8'h20 + 8'(i), 4);
        for (int i = 0; i < 3; i++) readCheck($sformatf("wrapA_pop%0d", i), A_POP, 32'h20 + i);
        for (int i = 0; i < 3; i++) setPin(8'h30 + 8'(i), 4);
        readCheck("wrap_status", A_STATUS, 32'h31);
        for (int i = 0; i < 3; i++) readCheck($sformatf("wrapB_pop%0d", i), A_POP, 32'h30 + i);

        // Simultaneous push and pop while full
        for (int i = 0; i < 4; i++) setPin(8'h40 + 8'(i), 4);
        readCheck("full_status", A_STATUS, 32'h43);
        PortIn = 8'h44;
        repeat (2) @(posedge clk);
        #1;
        readCheck("full_pp_pop", A_POP, 32'h40);
        readCheck("full_pp_status", A_STATUS, 32'h43);
        for (int i = 1; i < 5; i++) readCheck($sformatf("full_pp_drain%0d", i), A_POP, 32'h40 + i);

        // Simultaneous push and pop while empty: pop is a no-op
        PortIn = 8'h50;
        repeat (2) @(posedge clk);
        #1;
        readCheck("empty_pp_pop", A_POP, 32'h0);
        readCheck("empty_pp_status", A_STATUS, 32'h11);
        readCheck("empty_pp_data", A_POP, 32'h50);

        // Mid-operation reset pulse between edges
        setPin(8'h60, 4);
        setPin(8'h61, 4);
        doWrite(A_OUT, 32'h55);
        checkVal("mid_pre_pending", {31'b0, EventPending}, 32'h1);
        checkVal("mid_pre_portout", PortOut, 32'h55);
        #2;
        Address = A_STATUS; MemRead = 1'b1;
        reset = 1'b0;
        #0.5;
        checkVal("mid_portout", PortOut, 32'h0);
        checkVal("mid_pending", {31'b0, EventPending}, 32'h0);
        checkVal("mid_status", ReadData, 32'h0);
        #0.5;
        reset = 1'b1;
        MemRead = 1'b0; Address = 32'h0;
        @(posedge clk);
        #1;
        checkVal("mid_after_portout", PortOut, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

    // Safety net so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
